hash_checker: RTL and testbench



---
 rtl/hash_pkg.sv | 32 +++
 rtl/hash_round.sv | 21 ++
 rtl/hash_checker.sv | 129 ++++++++++++
 tb/tb_hash_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared hash definitions used by both the transmit-side hasher and the receive-side checker,
// so that both ends compute identical hashes bit for bit.
package hash_pkg;

    localparam logic [31:0] SEED          = 32'h811C_9DC5;
    localparam logic [31:0] RC            = 32'h9E37_79B9;
    localparam int          ROT_AMT_DEF   = 5;
    localparam int          FINAL_ROT_DEF = 16;
    localparam int          LEN_MAX       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The rotator that is shared by every hash stage; a distance of 0 leaves the word unchanged.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned amt);
        logic [4:0] a;
        a = amt[4:0];
        if (a == 5'd0) begin
            return x;
        end
        return (x << a) | (x >> (6'd32 - {1'b0, a}));
    endfunction

    // A declared length above the message size is treated as a full message.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > 4'(LEN_MAX)) ? 4'(LEN_MAX) : len;
    endfunction

endpackage

// File: rtl/hash_round.sv
// One byte round of the hash. This block is purely combinational, so the unrolled transmit
// hasher can chain copies of it and the checker can iterate it one round per cycle.
module hash_round
    import hash_pkg::*;
#(
    parameter int ROT_AMT = ROT_AMT_DEF
) (
    input  logic [31:0] state,
    input  logic [7:0]  data_byte,
    input  logic        enable,
    output logic [31:0] next_state
);

    logic [31:0] mixed;

    always_comb begin
        mixed      = rotl32(state ^ {24'h0, data_byte}, ROT_AMT) + RC;
        next_state = enable ? mixed : state;
    end

endmodule

// File: rtl/hash_checker.sv
// Receive-side checker: recomputes the message hash one byte round per cycle, compares it
// against the transmitted hash, and keeps a saturating count of mismatches.
module hash_checker
    import hash_pkg::*;
#(
    parameter int NUM_ROUNDS = 8,
    parameter int ROT_AMT    = ROT_AMT_DEF,
    parameter int FINAL_ROT  = FINAL_ROT_DEF,
    parameter int ERR_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_ROUNDS*8-1:0] data,
    input  logic [3:0]              data_len,
    input  logic [31:0]             exp_hash,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    match,
    output logic [31:0]             calc_hash,
    output logic [ERR_W-1:0]        err_count
);

    localparam int DATA_W = NUM_ROUNDS * 8;
    localparam int IDX_W  = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        len_q;
    logic [31:0]       exp_q;
    logic [31:0]       hash_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       calc_hash_q;
    logic              match_q;
    logic [ERR_W-1:0]  err_q;

    logic [7:0]        round_byte;
    logic              round_en;
    logic [31:0]       round_next;
    logic              last_round;
    logic [31:0]       final_hash;
    logic [3:0]        len_eff;
    logic              accept;

    // Bytes past the effective length leave the state untouched, but the round slot
    // is still spent, which keeps the result latency independent of the message length.
    assign round_byte = data_q[32'(idx_q) * 8 +: 8];
    assign round_en   = (32'(idx_q) < 32'(len_q));
    assign last_round = (idx_q == IDX_W'(NUM_ROUNDS - 1));
    assign len_eff    = clamp_len(data_len);
    assign accept     = (state_q == ST_IDLE) && in_valid;

    hash_round #(
        .ROT_AMT (ROT_AMT)
    ) u_round (
        .state      (hash_q),
        .data_byte  (round_byte),
        .enable     (round_en),
        .next_state (round_next)
    );

    assign final_hash = rotl32(round_next, FINAL_ROT);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_RUN;
            ST_RUN:  if (last_round) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            len_q  <= '0;
            exp_q  <= '0;
            hash_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            data_q <= data;
            len_q  <= len_eff;
            exp_q  <= exp_hash;
            hash_q <= SEED ^ {28'h0, len_eff};
            idx_q  <= '0;
        end else if (state_q == ST_RUN) begin
            hash_q <= round_next;
            idx_q  <= idx_q + 1'b1;
        end
    end

    // The result registers load on the final round only, so they hold steady while DONE waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            calc_hash_q <= '0;
            match_q     <= 1'b0;
            err_q       <= '0;
        end else if ((state_q == ST_RUN) && last_round) begin
            calc_hash_q <= final_hash;
            match_q     <= (final_hash == exp_q);
            if ((final_hash != exp_q) && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign match     = match_q;
    assign calc_hash = calc_hash_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_hash_checker.sv
// Self-checking bench for hash_checker: directed spec vectors plus randomized pairs
// checked against a loop-based reference hash.
module tb_hash_checker;

    localparam logic [31:0] REF_SEED = 32'h811C_9DC5;
    localparam logic [31:0] REF_RC   = 32'h9E37_79B9;
    localparam int          LATENCY  = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data;
    logic [3:0]  data_len;
    logic [31:0] exp_hash;
    logic        out_valid;
    logic        out_ready;
    logic        match;
    logic [31:0] calc_hash;
    logic [15:0] err_count;

    int n_checks  = 0;
    int n_pass    = 0;
    int n_fail    = 0;
    int err_model = 0;

    hash_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .data_len  (data_len),
        .exp_hash  (exp_hash),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .match     (match),
        .calc_hash (calc_hash),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int k);
        logic [63:0] dbl;
        dbl = {x, x} << k;
        return dbl[63:32];
    endfunction

    function automatic logic [31:0] ref_hash(input logic [63:0] d, input int len);
        int          n;
        logic [31:0] s;
        logic [7:0]  b;
        n = (len > 8) ? 8 : len;
        s = REF_SEED ^ 32'(n);
        for (int i = 0; i < n; i++) begin
            b = d[i*8 +: 8];
            s = ref_rotl(s ^ {24'h0, b}, 5) + REF_RC;
        end
        return ref_rotl(s, 16);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one pair and waits for the result; returns at the negedge where out_valid is first seen.
    task automatic get_result(input string tag, input logic [63:0] d, input logic [3:0] l,
                              input logic [31:0] h, output logic [31:0] model_hash);
        int wait_cnt;
        int lat;
        wait_cnt = 0;
        while (in_ready !== 1'b1 && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        data     = d;
        data_len = l;
        exp_hash = h;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        model_hash = ref_hash(d, int'(l));
        if (model_hash != h && err_model < 65535) err_model++;
        check({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        check({tag, "_calc_hash"}, 64'(calc_hash), 64'(model_hash));
        check({tag, "_match"}, 64'(match), 64'(model_hash == h));
        check({tag, "_err_count"}, 64'(err_count), 64'(err_model));
        check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] mh;
        logic [31:0] h15;
        logic [63:0] rd;
        logic [3:0]  rl;
        logic [31:0] rh;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data      = '0;
        data_len  = '0;
        exp_hash  = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_match", 64'(match), 64'd0);
        check("rst_calc_hash", 64'(calc_hash), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        get_result("empty", 64'h0, 4'd0, 32'h9DC5_811C, mh);
        check("empty_const", 64'(calc_hash), 64'h9DC5_811C);
        check("empty_match", 64'(match), 64'd1);
        handshake("empty");

        get_result("single", 64'h0, 4'd1, 32'h3249_C1CB, mh);
        check("single_const", 64'(calc_hash), 64'h3249_C1CB);
        handshake("single");

        get_result("mism1", 64'h0, 4'd1, 32'h3249_C1CA, mh);
        check("mism1_match", 64'(match), 64'd0);
        check("mism1_err", 64'(err_count), 64'd1);
        handshake("mism1");
        get_result("mism2", 64'h0, 4'd1, 32'h3249_C1CA, mh);
        check("mism2_err", 64'(err_count), 64'd2);
        handshake("mism2");

        rd = {$urandom, $urandom};
        get_result("clamp15", rd, 4'hF, 32'h0, mh);
        h15 = calc_hash;
        handshake("clamp15");
        get_result("clamp8", rd, 4'd8, 32'h0, mh);
        check("clamp_equal", 64'(calc_hash), 64'(h15));
        handshake("clamp8");

        // Backpressure: hold the result for 5 cycles while pulsing in_valid with junk.
        out_ready = 1'b0;
        rd = {$urandom, $urandom};
        get_result("bp", rd, 4'd6, 32'h1234_5678, mh);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            data     = {$urandom, $urandom};
            data_len = 4'd3;
            exp_hash = $urandom;
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_calc_hash", 64'(calc_hash), 64'(mh));
            check("bp_match", 64'(match), 64'(mh == 32'h1234_5678));
            check("bp_err", 64'(err_count), 64'(err_model));
        end
        in_valid = 1'b0;
        handshake("bp");
        @(negedge clk);
        check("bp_no_junk_run", 64'(in_ready), 64'd1);

        // Abort mid-RUN: reset at round 3 discards the work and clears the counter.
        rd = {$urandom, $urandom};
        data     = rd;
        data_len = 4'd8;
        exp_hash = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        err_model = 0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_err", 64'(err_count), 64'd0);
        check("abort_calc_hash", 64'(calc_hash), 64'd0);
        @(negedge clk);
        get_result("after_abort", rd, 4'd5, ref_hash(rd, 5), mh);
        handshake("after_abort");

        for (int i = 0; i < 24; i++) begin
            rd = {$urandom, $urandom};
            rl = 4'($urandom_range(0, 15));
            rh = ($urandom_range(0, 1) == 1) ? ref_hash(rd, int'(rl)) : $urandom;
            get_result("rand", rd, rl, rh, mh);
            handshake("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
